// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory request/response and decode handoff signals
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch stage with redirect flush
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic [31:0] rpc;
  assign rpc = {redirect_pc[31:2], 2'b00};
  assign bus.imem_req_addr = pc;
  // drop marks an in-flight response whose address was superseded by a redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      drop <= 1'b0;
      bus.imem_req_valid <= 1'b0;
      bus.instr_valid <= 1'b0;
      bus.instr <= NOP;
      bus.instr_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= rpc;
      bus.instr_valid <= 1'b0;
      case (state)
        REQ: begin
          state <= bus.imem_req_ready ? WAIT : REQ;
          drop <= bus.imem_req_ready;
          bus.imem_req_valid <= !bus.imem_req_ready;
        end
        WAIT: begin
          state <= bus.imem_rsp_valid ? REQ : WAIT;
          drop <= !bus.imem_rsp_valid;
          bus.imem_req_valid <= bus.imem_rsp_valid;
        end
        default: begin
          state <= REQ;
          bus.imem_req_valid <= 1'b1;
        end
      endcase
    end else
      case (state)
        IDLE: begin
          state <= REQ;
          bus.imem_req_valid <= 1'b1;
        end
        REQ: if (bus.imem_req_ready) begin
          state <= WAIT;
          bus.imem_req_valid <= 1'b0;
        end
        WAIT: if (bus.imem_rsp_valid) begin
          drop <= 1'b0;
          state <= drop ? REQ : HOLD;
          bus.imem_req_valid <= drop;
          bus.instr_valid <= !drop;
          if (!drop) begin
            bus.instr <= bus.imem_rsp_data;
            bus.instr_pc <= pc;
          end
        end
        HOLD: if (bus.instr_ready) begin
          pc <= pc + 32'd4;
          state <= REQ;
          bus.imem_req_valid <= 1'b1;
          bus.instr_valid <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: cycle-by-cycle directed vectors for instr_fetch
module tb_instr_fetch;
  typedef struct {
    logic rr, rv; logic [31:0] rd; logic ir, rdv; logic [31:0] rdp;
    logic qv; logic [31:0] qa; logic iv; logic [31:0] i, ipc;
  } vec_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  int tests = 0, fails = 0;
  vec_t tbl[$];
  instr_fetch_if bus();
  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic rr, logic rv, logic [31:0] rd, logic ir, logic rdv,
                             logic [31:0] rdp, logic qv, logic [31:0] qa, logic iv,
                             logic [31:0] i, logic [31:0] ipc);
    vec_t r;
    r.rr = rr; r.rv = rv; r.rd = rd; r.ir = ir; r.rdv = rdv; r.rdp = rdp;
    r.qv = qv; r.qa = qa; r.iv = iv; r.i = i; r.ipc = ipc;
    return r;
  endfunction
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic check_out(input int idx, input vec_t e);
    chk("imem_req_valid", idx, {31'b0, bus.imem_req_valid}, {31'b0, e.qv});
    chk("imem_req_addr", idx, bus.imem_req_addr, e.qa);
    chk("instr_valid", idx, {31'b0, bus.instr_valid}, {31'b0, e.iv});
    chk("instr", idx, bus.instr, e.i);
    chk("instr_pc", idx, bus.instr_pc, e.ipc);
  endtask
  task automatic step(input int idx, input vec_t s);
    bus.imem_req_ready = s.rr;
    bus.imem_rsp_valid = s.rv;
    bus.imem_rsp_data = s.rd;
    bus.instr_ready = s.ir;
    redirect_valid = s.rdv;
    redirect_pc = s.rdp;
    @(posedge clk);
    #1;
    check_out(idx, s);
  endtask
  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.instr_ready = 1'b0;
    // normal fetch of 0x0 and 0x4
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 1,32'h0,0,NOP,32'h0));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'h0,0,NOP,32'h0));
    tbl.push_back(v(1,1,32'hA000_0000,1,0,32'h0, 0,32'h0,1,32'hA000_0000,32'h0));
    tbl.push_back(v(1,1,32'hDEAD_BEEF,1,0,32'h0, 1,32'h4,0,32'hA000_0000,32'h0));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'h4,0,32'hA000_0000,32'h0));
    tbl.push_back(v(1,1,32'hA000_0004,1,0,32'h0, 0,32'h4,1,32'hA000_0004,32'h4));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 1,32'h8,0,32'hA000_0004,32'h4));
    // redirect in WAIT, stale 0x8 response three cycles later
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'h8,0,32'hA000_0004,32'h4));
    tbl.push_back(v(1,0,32'h0,1,1,32'h100, 0,32'h100,0,32'hA000_0004,32'h4));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'h100,0,32'hA000_0004,32'h4));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'h100,0,32'hA000_0004,32'h4));
    tbl.push_back(v(1,1,32'hA000_0008,1,0,32'h0, 1,32'h100,0,32'hA000_0004,32'h4));
    tbl.push_back(v(0,0,32'h0,1,0,32'h0, 1,32'h100,0,32'hA000_0004,32'h4));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'h100,0,32'hA000_0004,32'h4));
    tbl.push_back(v(1,1,32'h0050_0093,0,0,32'h0, 0,32'h100,1,32'h0050_0093,32'h100));
    // decode backpressure for 5 cycles
    for (int k = 0; k < 5; k++)
      tbl.push_back(v(1,1,32'hDEAD_BEEF,0,0,32'h0, 0,32'h100,1,32'h0050_0093,32'h100));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 1,32'h104,0,32'h0050_0093,32'h100));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'h104,0,32'h0050_0093,32'h100));
    tbl.push_back(v(1,1,32'hB000_0104,1,0,32'h0, 0,32'h104,1,32'hB000_0104,32'h104));
    // redirect in HOLD with same-cycle consume, then redirect on REQ handshake
    tbl.push_back(v(0,0,32'h0,1,1,32'h203, 1,32'h200,0,32'hB000_0104,32'h104));
    tbl.push_back(v(1,0,32'h0,1,1,32'hFFFF_FFFE, 0,32'hFFFF_FFFC,0,32'hB000_0104,32'h104));
    tbl.push_back(v(1,1,32'hC000_0200,1,0,32'h0, 1,32'hFFFF_FFFC,0,32'hB000_0104,32'h104));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'hFFFF_FFFC,0,32'hB000_0104,32'h104));
    tbl.push_back(v(1,1,32'hD000_FFFC,0,0,32'h0, 0,32'hFFFF_FFFC,1,32'hD000_FFFC,32'hFFFF_FFFC));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 1,32'h0,0,32'hD000_FFFC,32'hFFFF_FFFC));
    // redirect in REQ without handshake, in WAIT with response, double redirect in WAIT
    tbl.push_back(v(0,0,32'h0,1,1,32'h40, 1,32'h40,0,32'hD000_FFFC,32'hFFFF_FFFC));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'h40,0,32'hD000_FFFC,32'hFFFF_FFFC));
    tbl.push_back(v(1,1,32'hE000_0040,1,1,32'h80, 1,32'h80,0,32'hD000_FFFC,32'hFFFF_FFFC));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'h80,0,32'hD000_FFFC,32'hFFFF_FFFC));
    tbl.push_back(v(1,0,32'h0,1,1,32'h300, 0,32'h300,0,32'hD000_FFFC,32'hFFFF_FFFC));
    tbl.push_back(v(1,0,32'h0,1,1,32'h400, 0,32'h400,0,32'hD000_FFFC,32'hFFFF_FFFC));
    tbl.push_back(v(1,1,32'hF000_0080,1,0,32'h0, 1,32'h400,0,32'hD000_FFFC,32'hFFFF_FFFC));
    tbl.push_back(v(1,0,32'h0,1,0,32'h0, 0,32'h400,0,32'hD000_FFFC,32'hFFFF_FFFC));
    tbl.push_back(v(1,1,32'h1000_0400,0,0,32'h0, 0,32'h400,1,32'h1000_0400,32'h400));
    @(posedge clk);
    #1;
    check_out(0, v(0,0,32'h0,0,0,32'h0, 0,32'h0,0,NOP,32'h0));
    #2 rst_n = 1'b1;
    foreach (tbl[n]) step(n + 1, tbl[n]);
    // asynchronous reset while in WAIT, then a response during IDLE
    step(100, v(0,0,32'h0,1,0,32'h0, 1,32'h404,0,32'h1000_0400,32'h400));
    step(101, v(1,0,32'h0,1,0,32'h0, 0,32'h404,0,32'h1000_0400,32'h400));
    #2 rst_n = 1'b0;
    #1 check_out(102, v(0,0,32'h0,0,0,32'h0, 0,32'h0,0,NOP,32'h0));
    #1 rst_n = 1'b1;
    step(103, v(0,1,32'hBAD0_BAD0,1,0,32'h0, 1,32'h0,0,NOP,32'h0));
    step(104, v(0,1,32'hBAD0_BAD0,1,0,32'h0, 1,32'h0,0,NOP,32'h0));
    step(105, v(1,0,32'h0,1,0,32'h0, 0,32'h0,0,NOP,32'h0));
    step(106, v(1,1,32'h0000_0005,1,0,32'h0, 0,32'h0,1,32'h0000_0005,32'h0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
